// File: rtl/firinverse.sv
// firinverse: inverse (deconvolving) filter for the 4-tap FIR datapath.
// Reconstructs 4-bit samples x_n from the 8-bit filtered stream using
//   x_n = (y_n - B2*x_{n-1} - B1*x_{n-2} - B0*x_{n-3}) / B3
// with an 8-step restoring divider (one quotient bit per cycle, MSB first).
//
// Ports:
//   CLK        in   rising-edge clock
//   reset      in   synchronous, active-high
//   Din[7:0]   in   filtered sample y_n (FIR output mod 256)
//   in_valid   in   Din valid this cycle
//   in_ready   out  block can accept a sample (IDLE only)
//   B0..B3[2:0] in  coefficients, latched with Din; B3 is the divisor
//   Dout[3:0]  out  reconstructed sample (registered)
//   out_valid  out  one-cycle pulse, Dout/err valid
//   err        out  sample not exactly invertible (qualified by out_valid)
//
// Configuration macro: FIRINV_CHECK_EN
//   defined   -> err flags B3==0, quotient > 15, nonzero remainder; failed
//                samples output 0 and push 0 into the history.
//   undefined -> err tied low, Dout = Q[3:0] always (B3==0 gives 4'hF).

module firinverse (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] Din,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] B0,
  input  logic [2:0] B1,
  input  logic [2:0] B2,
  input  logic [2:0] B3,
  output logic [3:0] Dout,
  output logic       out_valid,
  output logic       err
);

  localparam int unsigned XW = 4;  // sample width
  localparam int unsigned CW = 3;  // coefficient width
  localparam int unsigned YW = 8;  // filtered data width
  localparam int unsigned PW = 7;  // product width (max 7*15 = 105)
  localparam int unsigned SW = 9;  // sum-of-products width (max 315)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [YW-1:0] y_q,   y_d;
  logic [CW-1:0] b0_q,  b0_d;
  logic [CW-1:0] b1_q,  b1_d;
  logic [CW-1:0] b2_q,  b2_d;
  logic [CW-1:0] b3_q,  b3_d;
  logic [XW-1:0] x1_q,  x1_d;
  logic [XW-1:0] x2_q,  x2_d;
  logic [XW-1:0] x3_q,  x3_d;
  logic [YW-1:0] quo_q, quo_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [CW-1:0] rem_q, rem_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [XW-1:0] dout_q, dout_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;

  logic          xfer;
  logic [PW-1:0] p0, p1, p2;
  logic [SW-1:0] psum;
  logic [YW-1:0] resid;
  logic [CW:0]   trial;
  logic          trial_ge;
  logic [XW-1:0] new_x;
  logic          new_err;

  assign xfer = in_valid && in_ready_q;

  // Residual: products at 7 bits, sum at 9 bits, subtraction wraps mod 256
  // exactly like the FIR's truncated output.
  assign p0    = PW'(b0_q) * PW'(x3_q);
  assign p1    = PW'(b1_q) * PW'(x2_q);
  assign p2    = PW'(b2_q) * PW'(x1_q);
  assign psum  = SW'(p0) + SW'(p1) + SW'(p2);
  assign resid = y_q - psum[YW-1:0];

  // One restoring-division step; with B3==0 the compare always succeeds,
  // which is what produces Q=8'hFF in the unguarded build.
  assign trial    = {rem_q, quo_q[YW-1]};
  assign trial_ge = trial >= {1'b0, b3_q};

  // Result qualification for the DONE state.
  always_comb begin
`ifdef FIRINV_CHECK_EN
    new_err = (b3_q == '0) || (quo_q > YW'(15)) || (rem_q != '0);
    new_x   = new_err ? '0 : quo_q[XW-1:0];
`else
    new_err = 1'b0;
    new_x   = quo_q[XW-1:0];
`endif
  end

  // State register and datapath registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      y_q         <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      b3_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      x3_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dout_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      b3_q        <= b3_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (xfer) state_d = CALC;
      CALC: state_d = DIV;
      DIV:  if (cnt_q == 3'd7) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    y_d         = y_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    b3_d        = b3_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    in_ready_d  = (state_d == IDLE);

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          y_d  = Din;
          b0_d = B0;
          b1_d = B1;
          b2_d = B2;
          b3_d = B3;
        end
      end
      CALC: begin
        quo_d = resid;
        rem_d = '0;
        cnt_d = '0;
      end
      DIV: begin
        cnt_d = cnt_q + 3'd1;
`ifdef FIRINV_CHECK_EN
        if (b3_q != '0) begin
`else
        begin
`endif
          if (trial_ge) begin
            rem_d = CW'(trial - {1'b0, b3_q});
            quo_d = {quo_q[YW-2:0], 1'b1};
          end else begin
            rem_d = trial[CW-1:0];
            quo_d = {quo_q[YW-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        dout_d      = new_x;
        err_d       = new_err;
        out_valid_d = 1'b1;
        x3_d        = x2_q;
        x2_d        = x1_q;
        x1_d        = new_x;
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign Dout      = dout_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_firinverse.sv
// Self-checking bench for firinverse: directed vector table, multi-cycle
// corner sequences (backpressure, reset in DIV) and randomized traffic
// checked against an arithmetic reference model.

module tb_firinverse;

`ifdef FIRINV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Din = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] B0 = '0, B1 = '0, B2 = '0, B3 = '0;
  logic [3:0] Dout;
  logic       out_valid;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference-model history x_{n-1}, x_{n-2}, x_{n-3}.
  int mx1 = 0, mx2 = 0, mx3 = 0;

  firinverse dut (
    .CLK(CLK), .reset(reset), .Din(Din), .in_valid(in_valid),
    .in_ready(in_ready), .B0(B0), .B1(B1), .B2(B2), .B3(B3),
    .Dout(Dout), .out_valid(out_valid), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decoder model straight from the defining equation.
  task automatic model(input int y, input int b0, input int b1, input int b2,
                       input int b3, output int d, output int e);
    int r, q, m;
    r = y - b2 * mx1 - b1 * mx2 - b0 * mx3;
    r = ((r % 256) + 256) % 256;
    if (b3 == 0) begin
      d = CHK ? 0 : 15;
      e = CHK ? 1 : 0;
    end else begin
      q = r / b3;
      m = r % b3;
      if (CHK && (q > 15 || m != 0)) begin
        d = 0; e = 1;
      end else begin
        d = q % 16; e = 0;
      end
    end
    mx3 = mx2; mx2 = mx1; mx1 = d;
  endtask

  // FIR encoder over the model history, to produce invertible samples.
  function automatic int enc(input int x, input int b0, input int b1,
                             input int b2, input int b3);
    return (b3 * x + b2 * mx1 + b1 * mx2 + b0 * mx3) % 256;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;
    mx1 = 0; mx2 = 0; mx3 = 0;
  endtask

  // One transfer; returns the result and checks the 10-cycle latency.
  task automatic send(input int y, input int b0, input int b1, input int b2,
                      input int b3, output int d, output int e);
    int w, lat;
    w = 0;
    while (!in_ready && w < 30) begin
      @(posedge CLK); #1; w++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    Din = 8'(y); B0 = 3'(b0); B1 = 3'(b1); B2 = 3'(b2); B3 = 3'(b3);
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    // Scramble inputs: only the latched values may matter.
    Din = 8'($urandom); B0 = 3'($urandom); B1 = 3'($urandom);
    B2 = 3'($urandom); B3 = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge CLK); #1; lat++;
      if (lat == 5) check("busy_in_ready", int'(in_ready), 0);
    end
    check("latency", lat, 10);
    d = int'(Dout);
    e = int'(err);
  endtask

  typedef struct {
    int    rst;
    int    y, b0, b1, b2, b3;
    int    ed, ee;
    string nm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int d, e, md, me;
    int exp_d[$];
    int exp_e[$];
    int last_ov, n_ov, n_acc, bb0, bb1, bb2, bb3, x, y;

    tbl[0] = '{1,   3, 1, 1, 1, 1,  3, 0, "b1111_y3"};
    tbl[1] = '{0,   8, 1, 1, 1, 1,  5, 0, "b1111_y8"};
    tbl[2] = '{0,  15, 1, 1, 1, 1,  7, 0, "b1111_y15"};
    tbl[3] = '{1, 105, 7, 7, 7, 7, 15, 0, "wrap_y105"};
    tbl[4] = '{0, 210, 7, 7, 7, 7, 15, 0, "wrap_y210"};
    tbl[5] = '{0,  59, 7, 7, 7, 7, 15, 0, "wrap_y59"};
    tbl[6] = '{1,   7, 0, 0, 0, 2, CHK ? 0 : 3, CHK ? 1 : 0, "inexact"};
    tbl[7] = '{0,   6, 0, 0, 1, 2, CHK ? 3 : 1, 0, "after_inexact"};
    tbl[8] = '{1,   4, 0, 0, 0, 0, CHK ? 0 : 15, CHK ? 1 : 0, "div_zero"};
    tbl[9] = '{1,  16, 0, 0, 0, 1, 0, CHK ? 1 : 0, "q_over_15"};

    do_reset();
    check("rst_dout", int'(Dout), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst != 0) do_reset();
      model(tbl[i].y, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, md, me);
      send(tbl[i].y, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, d, e);
      check({tbl[i].nm, "_dout"}, d, tbl[i].ed);
      check({tbl[i].nm, "_err"}, e, tbl[i].ee);
      @(posedge CLK); #1;
      check({tbl[i].nm, "_pulse"}, int'(out_valid), 0);
    end

    // Reset during DIV: in-flight sample dropped, history cleared.
    do_reset();
    send(3, 1, 1, 1, 1, d, e);
    @(posedge CLK); #1;
    Din = 8'd8; B0 = 3'd1; B1 = 3'd1; B2 = 3'd1; B3 = 3'd1;
    in_valid = 1'b1;
    @(posedge CLK); #1;            // transfer edge t
    in_valid = 1'b0;
    @(posedge CLK); @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;            // edge t+4 samples reset
    reset = 1'b0;
    mx1 = 0; mx2 = 0; mx3 = 0;
    check("rstdiv_in_ready", int'(in_ready), 1);
    check("rstdiv_out_valid", int'(out_valid), 0);
    n_ov = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) n_ov++;
      @(posedge CLK); #1;
    end
    check("rstdiv_no_output", n_ov, 0);
    send(3, 1, 1, 1, 1, d, e);
    check("rstdiv_dout", d, 3);
    check("rstdiv_err", e, 0);

    // Backpressure: in_valid held high, Din changes every cycle.
    do_reset();
    bb0 = $urandom_range(0, 7); bb1 = $urandom_range(0, 7);
    bb2 = $urandom_range(0, 7); bb3 = $urandom_range(1, 7);
    B0 = 3'(bb0); B1 = 3'(bb1); B2 = 3'(bb2); B3 = 3'(bb3);
    in_valid = 1'b1;
    last_ov = -1; n_ov = 0; n_acc = 0;
    for (int c = 0; c < 82; c++) begin
      if (out_valid) begin
        if (exp_d.size() > 0) begin
          check("bp_dout", int'(Dout), exp_d.pop_front());
          check("bp_err", int'(err), exp_e.pop_front());
        end else check("bp_spurious", 1, 0);
        if (last_ov >= 0) check("bp_spacing", c - last_ov, 11);
        last_ov = c;
        n_ov++;
      end
      if (in_ready) begin
        y = enc($urandom_range(0, 15), bb0, bb1, bb2, bb3);
        Din = 8'(y);
        model(y, bb0, bb1, bb2, bb3, md, me);
        exp_d.push_back(md);
        exp_e.push_back(me);
        n_acc++;
      end else Din = 8'($urandom);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) begin
        if (exp_d.size() > 0) begin
          check("bp_dout", int'(Dout), exp_d.pop_front());
          check("bp_err", int'(err), exp_e.pop_front());
        end else check("bp_spurious", 1, 0);
        n_ov++;
      end
      @(posedge CLK); #1;
    end
    check("bp_count", n_ov, n_acc);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bb0 = $urandom_range(0, 7); bb1 = $urandom_range(0, 7);
      bb2 = $urandom_range(0, 7); bb3 = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom_range(0, 15);
        y = enc(x, bb0, bb1, bb2, bb3);
      end else y = $urandom_range(0, 255);
      model(y, bb0, bb1, bb2, bb3, md, me);
      send(y, bb0, bb1, bb2, bb3, d, e);
      check("rand_dout", d, md);
      check("rand_err", e, me);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
